vga_text_raster: RTL
====================

# vga_text_raster

Parametrised raster and character-cell address generator for text-mode VGA output. It produces sync and blanking timing, a frame-buffer cell address, and the glyph row and column for any resolution and character-cell geometry. It also generates a hardware cursor with an optional blink. It sits between the pixel clock domain timing and the frame buffer / font-colour lookup. The address path uses incremental counters rather than divide and multiply.

## Interface
- H_ACTIVE, 640, visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48: horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33: vertical porch and sync widths in lines
- COLS, 80, text columns; ROWS, 25, text rows
- CELL_W, 8, pixels per cell horizontally; CELL_H, 16, lines per cell
- V_BORDER, 40, blank lines above the text area (the same count is left below when it fits)
- PIPE_DEPTH, 2, cycles of downstream frame-buffer and LUT latency to compensate for
- BLINK_FRAMES, 16, frames per blink half-period
- SYNC_POL, 0, asserted level of hsync and vsync
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-low reset
- cursor_enabled  in  1  cursor display enable
- cursor_pos  in  AW  cell index of the cursor; AW = $clog2(COLS*ROWS)
- cursor_scan_start, cursor_scan_end  in  RW  first and last cursor line within the cell; RW = $clog2(CELL_H)
- fb_address  out  AW  cell index = text_row*COLS + text_col
- glyph_row  out  RW  line within the cell
- glyph_col  out  $clog2(CELL_W)  pixel within the cell
- hsync, vsync  out  1  sync outputs, delayed to align with pixel data
- is_blank  out  1  pixel outside the text area or outside active video, aligned with pixel data
- render_cursor  out  1  cursor pixel, aligned with pixel data
- frame_start  out  1  one-cycle pulse at h=0, v=0 (undelayed)
- blink_phase  out  1  current blink half-period

## Operation
- Counter h_cnt runs 0..H_TOTAL-1 and wraps. H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
- Counter v_cnt advances when h_cnt wraps and runs 0..V_TOTAL-1.
- hsync is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync uses the same rule on v_cnt.
- The text area is h_cnt < COLS*CELL_W and v_cnt in [V_BORDER, V_BORDER+ROWS*CELL_H). Anything else is blank.
- Cell tracking:
  - glyph_col increments per pixel and wraps at CELL_W-1. On each wrap, col_addr increments.
  - At the end of each active line, col_addr reloads from row_base. glyph_row increments and wraps at CELL_H-1.
  - On a glyph_row wrap, row_base += COLS.
  - At v_cnt == V_BORDER, row_base, glyph_row and glyph_col all clear to 0.
- Outside the text area, fb_address, glyph_row and glyph_col hold 0.
- The cursor hit condition requires all of the following:
  - cursor_enabled is set;
  - fb_address == cursor_pos;
  - cursor_scan_start <= glyph_row <= cursor_scan_end;
  - the pixel is inside the text area.
- If cursor_pos >= COLS*ROWS, or cursor_scan_start > cursor_scan_end, the cursor never renders.
- Blink counter: increments on frame_start. When it reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- The cursor inputs are sampled every cycle. A change takes effect on the next pixel.

## Timing
- fb_address, glyph_row and glyph_col are registered and valid 1 cycle after the counters.
- hsync, vsync, is_blank and render_cursor pass through a shift register of PIPE_DEPTH stages from the address-valid cycle. This aligns them with data returning from the frame buffer and LUT.
- Reset values:
  - all counters, fb_address, glyph_row, glyph_col, render_cursor, frame_start and blink_phase are 0;
  - is_blank is 1;
  - hsync and vsync are at !SYNC_POL, including every pipe stage.
- Reset may be asserted at any point in a frame. On the cycle after release, all outputs take their reset values and counting resumes from h=0, v=0.
- Simultaneous line wrap and frame wrap: the frame wrap takes priority, and v_cnt goes to 0.

## Configuration
- VGA_CURSOR_BLINK_EN defined:
  - render_cursor is the cursor hit ANDed with !blink_phase;
  - the blink counter is instantiated.
- VGA_CURSOR_BLINK_EN not defined:
  - the cursor is solid;
  - the blink counter is removed;
  - blink_phase is tied to 0.

## Test plan
- Reset: hold reset low for 5 cycles mid-frame -> hsync=vsync=1, is_blank=1, fb_address=0, render_cursor=0. First frame_start occurs 1 cycle after release.
- Sync timing (defaults): hsync low for 96 cycles and repeats every 800 cycles; vsync low for 2 lines and repeats every 525 lines. Both are offset by 1+PIPE_DEPTH from counter position.
- Addressing: (v=40, h=0) -> fb_address 0; (v=56, h=8) -> 81, glyph_row 0; (v=439, h=639) -> 1999, glyph_row 15, glyph_col 7.
- Border: v=0..39 and v=440..479 -> is_blank=1 and fb_address=0 throughout.
- Cursor: cursor_pos=81, scan 14..15, enabled -> render_cursor high only for v=70..71, h=8..15. With scan_start=15 and scan_end=14 -> never high.
- Blink (macro defined, BLINK_FRAMES=16): the cursor is visible in frames 0-15 and hidden in frames 16-31. Without the macro, the cursor is visible in all 32 frames.

Source files
------------

// File: rtl/vga_text_raster.sv
// Text-mode VGA raster timing and character-cell address generator with hardware cursor.
// Define VGA_CURSOR_BLINK_EN to build the blink counter; otherwise the cursor is solid.
module vga_text_raster #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int COLS         = 80,
  parameter int ROWS         = 25,
  parameter int CELL_W       = 8,
  parameter int CELL_H       = 16,
  parameter int V_BORDER     = 40,
  parameter int PIPE_DEPTH   = 2,
  parameter int BLINK_FRAMES = 16,
  parameter bit SYNC_POL     = 1'b0,
  localparam int AW = $clog2(COLS * ROWS),
  localparam int RW = $clog2(CELL_H),
  localparam int CW = $clog2(CELL_W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cursor_enabled,
  input  logic [AW-1:0] cursor_pos,
  input  logic [RW-1:0] cursor_scan_start,
  input  logic [RW-1:0] cursor_scan_end,
  output logic [AW-1:0] fb_address,
  output logic [RW-1:0] glyph_row,
  output logic [CW-1:0] glyph_col,
  output logic          hsync,
  output logic          vsync,
  output logic          is_blank,
  output logic          render_cursor,
  output logic          frame_start,
  output logic          blink_phase
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int TEXT_H_END = (COLS * CELL_W < H_ACTIVE) ? COLS * CELL_W : H_ACTIVE;
  localparam int TEXT_V_END = (V_BORDER + ROWS * CELL_H < V_ACTIVE) ? V_BORDER + ROWS * CELL_H : V_ACTIVE;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0] TEXT_H_LIM = HW'(TEXT_H_END);
  localparam logic [VW-1:0] TEXT_V_LIM = VW'(TEXT_V_END);
  localparam logic [VW-1:0] BORDER_TOP = VW'(V_BORDER);
  localparam logic [CW-1:0] COL_LAST   = CW'(CELL_W - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(CELL_H - 1);
  localparam logic [AW-1:0] ROW_STEP   = AW'(COLS);
  localparam logic [AW:0]   CELL_COUNT = (AW + 1)'(COLS * ROWS);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [VW-1:0] v_next;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [AW-1:0] col_addr;
  logic [AW-1:0] row_base;
  logic          line_end;
  logic          v_text;
  logic          in_text;
  logic          hit;
  logic          show_cursor;
  logic          hs_now;
  logic          vs_now;

  logic [PIPE_DEPTH:0] hs_pipe;
  logic [PIPE_DEPTH:0] vs_pipe;
  logic [PIPE_DEPTH:0] blank_pipe;
  logic [PIPE_DEPTH:0] cursor_pipe;

  always_comb begin
    line_end = (h_cnt == H_LAST);
    v_next   = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    v_text   = (v_cnt >= BORDER_TOP) && (v_cnt < TEXT_V_LIM);
    in_text  = v_text && (h_cnt < TEXT_H_LIM);
    hs_now   = (h_cnt >= HS_START && h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
    vs_now   = (v_cnt >= VS_START && v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
    hit      = cursor_enabled && in_text && (col_addr == cursor_pos) &&
               ({1'b0, cursor_pos} < CELL_COUNT) &&
               (row_cnt >= cursor_scan_start) && (row_cnt <= cursor_scan_end);
  end

  // Cell tracking follows the counters incrementally; col_addr may run past the text
  // area within a line, which is harmless because it is masked and reloaded at line end.
  always_ff @(posedge clk) begin
    if (!reset) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      col_cnt  <= '0;
      row_cnt  <= '0;
      col_addr <= '0;
      row_base <= '0;
    end else if (line_end) begin
      h_cnt   <= '0;
      v_cnt   <= v_next;
      col_cnt <= '0;
      if (v_next == BORDER_TOP) begin
        row_base <= '0;
        row_cnt  <= '0;
        col_addr <= '0;
      end else if (v_text && row_cnt == ROW_LAST) begin
        row_cnt  <= '0;
        row_base <= row_base + ROW_STEP;
        col_addr <= row_base + ROW_STEP;
      end else begin
        if (v_text) row_cnt <= row_cnt + 1'b1;
        col_addr <= row_base;
      end
    end else begin
      h_cnt <= h_cnt + 1'b1;
      if (col_cnt == COL_LAST) begin
        col_cnt  <= '0;
        col_addr <= col_addr + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

`ifdef VGA_CURSOR_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  logic [BW-1:0] blink_cnt;
  logic          frame_end;

  assign frame_end   = line_end && (v_cnt == V_LAST);
  assign show_cursor = hit && !blink_phase;

  // Advancing at the frame boundary gives the frame right after reset a full half-period.
  always_ff @(posedge clk) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`else
  assign show_cursor = hit;
  assign blink_phase = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      fb_address  <= '0;
      glyph_row   <= '0;
      glyph_col   <= '0;
      frame_start <= 1'b0;
      hs_pipe     <= {(PIPE_DEPTH + 1){~SYNC_POL}};
      vs_pipe     <= {(PIPE_DEPTH + 1){~SYNC_POL}};
      blank_pipe  <= '1;
      cursor_pipe <= '0;
    end else begin
      fb_address     <= in_text ? col_addr : '0;
      glyph_row      <= in_text ? row_cnt : '0;
      glyph_col      <= in_text ? col_cnt : '0;
      frame_start    <= (h_cnt == '0) && (v_cnt == '0);
      hs_pipe[0]     <= hs_now;
      vs_pipe[0]     <= vs_now;
      blank_pipe[0]  <= !in_text;
      cursor_pipe[0] <= show_cursor;
      for (int i = 1; i <= PIPE_DEPTH; i++) begin
        hs_pipe[i]     <= hs_pipe[i-1];
        vs_pipe[i]     <= vs_pipe[i-1];
        blank_pipe[i]  <= blank_pipe[i-1];
        cursor_pipe[i] <= cursor_pipe[i-1];
      end
    end
  end

  assign hsync         = hs_pipe[PIPE_DEPTH];
  assign vsync         = vs_pipe[PIPE_DEPTH];
  assign is_blank      = blank_pipe[PIPE_DEPTH];
  assign render_cursor = cursor_pipe[PIPE_DEPTH];

endmodule
